// File: rtl/tournament_update_ctrl.sv
// Tournament predictor training controller: in-order in-flight queue, resolve matching,
// gh/ph/chooser training commands and post-reset chooser initialisation sweep.
module tournament_update_ctrl #(
  parameter int unsigned n        = 32,
  parameter int unsigned size     = 16,
  parameter int unsigned depth    = 4,
  parameter logic [1:0]  init_val = 2'b01
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      predict_valid,
  input  logic [n-1:0]              PC,
  input  logic                      prediction_gh,
  input  logic                      prediction_ph,
  input  logic                      prediction,
  output logic                      predict_ready,
  input  logic                      resolve_valid,
  input  logic                      fix_result,
  output logic                      upd_valid,
  output logic [$clog2(size)-1:0]   upd_index,
  output logic                      upd_taken,
  output logic                      upd_meta_en,
  output logic                      upd_meta_inc,
  output logic                      mispredict,
  output logic                      init_we,
  output logic [$clog2(size)-1:0]   init_index,
  output logic                      err_underflow
);

  localparam int unsigned idx_w = $clog2(size);
  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = $clog2(depth) + 1;

  typedef enum logic {INIT, RUN} state_e;

  typedef struct packed {
    logic [idx_w-1:0] idx;
    logic             gh;
    logic             ph;
    logic             pred;
  } entry_t;

  state_e             state_q, state_d;
  logic [idx_w-1:0]   init_cnt_q, init_cnt_d;
  logic [ptr_w-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [cnt_w-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               upd_valid_q, upd_valid_d;
  logic [idx_w-1:0]   upd_index_q, upd_index_d;
  logic               upd_taken_q, upd_taken_d;
  logic               upd_meta_en_q, upd_meta_en_d;
  logic               upd_meta_inc_q, upd_meta_inc_d;
  logic               mispredict_q, mispredict_d;

  entry_t             mem_q [depth];
  entry_t             push_entry_c;
  entry_t             head_c;
  logic               push_c, pop_c, flush_c, underflow_c;
  logic               unused_pc;

  // Only the word-aligned index bits of the PC reach the tables.
  assign unused_pc = ^{PC[n-1:idx_w+2], PC[1:0], init_val};

  assign predict_ready = (state_q == RUN) && (count_q != cnt_w'(depth));
  assign push_c        = predict_valid && predict_ready;
  assign head_c        = mem_q[rd_q];
  assign pop_c         = (state_q == RUN) && resolve_valid && (count_q != '0);
  assign underflow_c   = (state_q == RUN) && resolve_valid && (count_q == '0);
  assign flush_c       = pop_c && (head_c.pred != fix_result);

  assign push_entry_c = '{idx: PC[idx_w+1:2], gh: prediction_gh,
                          ph: prediction_ph, pred: prediction};

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    wr_d           = wr_q;
    rd_d           = rd_q;
    count_d        = count_q;
    err_d          = err_q || underflow_c;
    upd_valid_d    = pop_c;
    upd_index_d    = '0;
    upd_taken_d    = 1'b0;
    upd_meta_en_d  = 1'b0;
    upd_meta_inc_d = 1'b0;
    mispredict_d   = 1'b0;

    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + idx_w'(1);
        if (init_cnt_q == idx_w'(size - 1)) state_d = RUN;
      end
      RUN: ;
      default: state_d = INIT;
    endcase

    if (pop_c) begin
      upd_index_d    = head_c.idx;
      upd_taken_d    = fix_result;
      upd_meta_en_d  = head_c.gh != head_c.ph;
      upd_meta_inc_d = head_c.gh == fix_result;
      mispredict_d   = head_c.pred != fix_result;
    end

    // A mispredict discards everything younger, including a same-cycle push.
    if (flush_c) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_c) wr_d = wr_q + ptr_w'(1);
      if (pop_c)  rd_d = rd_q + ptr_w'(1);
      count_d = count_q + cnt_w'(push_c) - cnt_w'(pop_c);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= INIT;
      init_cnt_q     <= '0;
      wr_q           <= '0;
      rd_q           <= '0;
      count_q        <= '0;
      err_q          <= 1'b0;
      upd_valid_q    <= 1'b0;
      upd_index_q    <= '0;
      upd_taken_q    <= 1'b0;
      upd_meta_en_q  <= 1'b0;
      upd_meta_inc_q <= 1'b0;
      mispredict_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      count_q        <= count_d;
      err_q          <= err_d;
      upd_valid_q    <= upd_valid_d;
      upd_index_q    <= upd_index_d;
      upd_taken_q    <= upd_taken_d;
      upd_meta_en_q  <= upd_meta_en_d;
      upd_meta_inc_q <= upd_meta_inc_d;
      mispredict_q   <= mispredict_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by count/pointers.
  always_ff @(posedge clock) begin
    if (push_c) mem_q[wr_q] <= push_entry_c;
  end

  assign init_we       = (state_q == INIT);
  assign init_index    = init_cnt_q;
  assign upd_valid     = upd_valid_q;
  assign upd_index     = upd_index_q;
  assign upd_taken     = upd_taken_q;
  assign upd_meta_en   = upd_meta_en_q;
  assign upd_meta_inc  = upd_meta_inc_q;
  assign mispredict    = mispredict_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_tournament_update_ctrl.sv
// Directed bench for tournament_update_ctrl with hand-computed expectations.
module tb_tournament_update_ctrl;

  localparam int unsigned IW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          predict_valid;
  logic [31:0]   PC;
  logic          prediction_gh, prediction_ph, prediction;
  logic          predict_ready;
  logic          resolve_valid, fix_result;
  logic          upd_valid;
  logic [IW-1:0] upd_index;
  logic          upd_taken, upd_meta_en, upd_meta_inc, mispredict;
  logic          init_we;
  logic [IW-1:0] init_index;
  logic          err_underflow;

  int total = 0;
  int bad   = 0;

  tournament_update_ctrl #(.n(32), .size(16), .depth(4), .init_val(2'b01)) dut (
    .clock(clock), .reset(reset), .predict_valid(predict_valid), .PC(PC),
    .prediction_gh(prediction_gh), .prediction_ph(prediction_ph),
    .prediction(prediction), .predict_ready(predict_ready),
    .resolve_valid(resolve_valid), .fix_result(fix_result),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_meta_en(upd_meta_en), .upd_meta_inc(upd_meta_inc),
    .mispredict(mispredict), .init_we(init_we), .init_index(init_index),
    .err_underflow(err_underflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic gh, input logic ph, input logic pr);
    predict_valid = 1'b1; PC = pc;
    prediction_gh = gh; prediction_ph = ph; prediction = pr;
    tick();
    predict_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; predict_valid = 1'b0; PC = '0;
    prediction_gh = 1'b0; prediction_ph = 1'b0; prediction = 1'b0;
    resolve_valid = 1'b0; fix_result = 1'b0;

    // 1. reset and chooser sweep
    tick(); tick();
    reset = 1'b0;
    chk("rst_upd_valid", 8'(upd_valid), 8'd0);
    chk("rst_err", 8'(err_underflow), 8'd0);
    for (int i = 0; i < 16; i++) begin
      chk("init_we", 8'(init_we), 8'd1);
      chk("init_index", 8'(init_index), 8'(i));
      chk("init_ready", 8'(predict_ready), 8'd0);
      chk("init_upd", 8'(upd_valid), 8'd0);
      tick();
    end
    chk("run_init_we", 8'(init_we), 8'd0);
    chk("run_ready", 8'(predict_ready), 8'd1);

    // 2. agreeing hit
    push(32'h40, 1'b1, 1'b1, 1'b1);
    resolve_valid = 1'b1; fix_result = 1'b1;
    tick();
    resolve_valid = 1'b0;
    chk("hit_valid", 8'(upd_valid), 8'd1);
    chk("hit_index", 8'(upd_index), 8'd0);
    chk("hit_taken", 8'(upd_taken), 8'd1);
    chk("hit_meta_en", 8'(upd_meta_en), 8'd0);
    chk("hit_misp", 8'(mispredict), 8'd0);
    tick();
    chk("hit_pulse_end", 8'(upd_valid), 8'd0);

    // 3. disagreement with mispredict
    push(32'h44, 1'b1, 1'b0, 1'b0);
    resolve_valid = 1'b1; fix_result = 1'b1;
    tick();
    resolve_valid = 1'b0;
    chk("dis_valid", 8'(upd_valid), 8'd1);
    chk("dis_index", 8'(upd_index), 8'd1);
    chk("dis_meta_en", 8'(upd_meta_en), 8'd1);
    chk("dis_meta_inc", 8'(upd_meta_inc), 8'd1);
    chk("dis_misp", 8'(mispredict), 8'd1);
    chk("dis_ready", 8'(predict_ready), 8'd1);

    // 4. full queue, dropped push, in-order drain
    push(32'h48, 1'b1, 1'b1, 1'b1); chk("full_rdy1", 8'(predict_ready), 8'd1);
    push(32'h4C, 1'b1, 1'b1, 1'b1); chk("full_rdy2", 8'(predict_ready), 8'd1);
    push(32'h50, 1'b1, 1'b1, 1'b1); chk("full_rdy3", 8'(predict_ready), 8'd1);
    push(32'h54, 1'b1, 1'b1, 1'b1); chk("full_rdy4", 8'(predict_ready), 8'd0);
    push(32'h58, 1'b1, 1'b1, 1'b1); chk("full_rdy5", 8'(predict_ready), 8'd0);
    chk("full_no_upd", 8'(upd_valid), 8'd0);
    resolve_valid = 1'b1; fix_result = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_valid", 8'(upd_valid), 8'd1);
      chk("drain_index", 8'(upd_index), 8'(2 + k));
      chk("drain_misp", 8'(mispredict), 8'd0);
    end
    resolve_valid = 1'b0;
    chk("drain_err", 8'(err_underflow), 8'd0);
    chk("drain_ready", 8'(predict_ready), 8'd1);

    // 5. flush with same-cycle push, then underflow
    push(32'h60, 1'b1, 1'b0, 1'b1);
    push(32'h64, 1'b1, 1'b0, 1'b1);
    push(32'h68, 1'b1, 1'b0, 1'b1);
    predict_valid = 1'b1; PC = 32'h6C;
    resolve_valid = 1'b1; fix_result = 1'b0;
    tick();
    predict_valid = 1'b0;
    chk("flush_valid", 8'(upd_valid), 8'd1);
    chk("flush_index", 8'(upd_index), 8'd8);
    chk("flush_taken", 8'(upd_taken), 8'd0);
    chk("flush_meta_en", 8'(upd_meta_en), 8'd1);
    chk("flush_meta_inc", 8'(upd_meta_inc), 8'd0);
    chk("flush_misp", 8'(mispredict), 8'd1);
    tick();
    resolve_valid = 1'b0;
    chk("uf_no_upd", 8'(upd_valid), 8'd0);
    chk("uf_err", 8'(err_underflow), 8'd1);
    tick();
    chk("uf_sticky", 8'(err_underflow), 8'd1);
    chk("uf_quiet", 8'(upd_valid), 8'd0);

    // 6. reset mid-run with pending entries
    push(32'h70, 1'b1, 1'b1, 1'b1);
    push(32'h74, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_upd", 8'(upd_valid), 8'd0);
    chk("mrst_err", 8'(err_underflow), 8'd0);
    chk("mrst_init_we", 8'(init_we), 8'd1);
    chk("mrst_init_idx", 8'(init_index), 8'd0);
    chk("mrst_ready", 8'(predict_ready), 8'd0);
    resolve_valid = 1'b1; fix_result = 1'b1;
    tick();
    resolve_valid = 1'b0;
    chk("mrst_init_idx1", 8'(init_index), 8'd1);
    chk("mrst_init_ign", 8'(upd_valid), 8'd0);
    chk("mrst_init_err", 8'(err_underflow), 8'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("mrst_run_ready", 8'(predict_ready), 8'd1);
    chk("mrst_run_we", 8'(init_we), 8'd0);
    resolve_valid = 1'b1; fix_result = 1'b1;
    tick();
    resolve_valid = 1'b0;
    chk("mrst_discard_upd", 8'(upd_valid), 8'd0);
    chk("mrst_discard_err", 8'(err_underflow), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tournament_update_ctrl.md
Name: tournament_update_ctrl

Overview:
Sequencing and training controller for the tournament branch predictor. It tracks in-flight predictions in order and matches each one to its resolved outcome (fix_result). It then issues one training command per resolved branch to the global-history (gh) predictor, the per-PC-history (ph) predictor and the chooser (meta) table. After every reset it sweeps the chooser table to its initial value, and it gates new predictions until that sweep completes.

Parameters:
n, 32, PC width in bits
size, 16, chooser/predictor table entries (power of 2); idx_w = $clog2(size)
depth, 4, in-flight queue entries (power of 2, >=2)
init_val, 2'b01, chooser counter value written during init sweep (weakly prefer ph)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
predict_valid  in  1  a prediction was issued this cycle
PC  in  n  PC of the predicted branch
prediction_gh  in  1  gh predictor direction
prediction_ph  in  1  ph predictor direction
prediction  in  1  final tournament direction
predict_ready  out  1  controller can accept a prediction this cycle
resolve_valid  in  1  oldest in-flight branch resolved this cycle
fix_result  in  1  actual direction (1 = taken)
upd_valid  out  1  training command valid (registered)
upd_index  out  idx_w  table index = PC[idx_w+1:2] of the trained branch
upd_taken  out  1  actual outcome, for gh/ph training
upd_meta_en  out  1  chooser counter must move
upd_meta_inc  out  1  1 = move toward gh, 0 = toward ph
mispredict  out  1  final prediction was wrong (registered, 1-cycle pulse)
init_we  out  1  chooser init write strobe
init_index  out  idx_w  chooser init write address
err_underflow  out  1  sticky: resolve arrived with an empty queue

Behaviour:
- Reset (clock edge with reset=1):
  - state <= INIT; queue empty; wr/rd pointers 0; init counter 0.
  - All outputs 0, except init_we=1 and init_index=0 in the first cycle after reset release.
- Reset asserted mid-operation: same as above. All pending entries are discarded with no upd_valid.
- FSM states: INIT and RUN.
  - INIT: init_we=1, init_index = counter, counter +1 per cycle; predict_ready=0; resolve_valid ignored.
  - INIT -> RUN after the cycle with init_index = size-1. The sweep lasts exactly size cycles.
  - RUN: init_we=0. No other exit except reset.
- Queue push (RUN only):
  - Accept when predict_valid && predict_ready.
  - Store {PC[idx_w+1:2], prediction_gh, prediction_ph, prediction}.
  - predict_ready = (state==RUN) && !full, combinational from registered state only.
  - predict_valid while predict_ready=0 is dropped; nothing is stored.
- Queue pop (RUN):
  - resolve_valid pops the head, which is the oldest entry pushed in an earlier cycle.
  - An entry pushed in the same cycle is never matched by that cycle's resolve.
- Training (registered, 1-cycle latency after the resolve_valid cycle):
  - upd_valid=1; upd_index = head index; upd_taken = fix_result.
  - upd_meta_en = (head gh != head ph).
  - upd_meta_inc = (head gh == fix_result), meaningful only when upd_meta_en=1.
  - mispredict = (head prediction != fix_result).
  - All of these are 0 in cycles with no valid pop.
- Mispredict flush: on a resolve with a mispredict, every remaining entry is wrong-path.
  - The queue is cleared at that same clock edge, including any push accepted in that cycle.
  - The next cycle starts with an empty queue.
- Simultaneous push and pop on a non-empty, non-mispredicting resolve: both happen; the count is unchanged.
  - This applies even when full: ready is 0 when full, so no push can occur in that case.
- Underflow: resolve_valid in RUN with the queue empty (the prior-cycle count is 0).
  - The resolve is ignored; no upd_valid.
  - err_underflow is set to 1 and stays set until reset.
- Pointers are idx of $clog2(depth) bits and wrap modulo depth.
  - Full/empty are distinguished by a separate count register of $clog2(depth)+1 bits.

Test Plan:
1. Reset sweep: size=16, hold reset 2 cycles then release -> init_we=1 for exactly 16 cycles, init_index 0..15; predict_ready=0 throughout, then 1; all upd_* = 0.
2. Agreeing hit: PC=0x40, gh=1, ph=1, pred=1, then resolve fix_result=1 -> next cycle upd_valid=1, upd_index=0, upd_taken=1, upd_meta_en=0, mispredict=0.
3. Disagreement training: PC=0x44, gh=1, ph=0, pred=0, fix_result=1 -> upd_index=1, upd_meta_en=1, upd_meta_inc=1, mispredict=1, queue empty afterwards.
4. Full queue: push 4 predictions without resolve -> predict_ready=0 after the 4th; a 5th predict_valid is dropped. Four correct resolves -> four upd_valid pulses with indices in push order.
5. Flush: push 3 entries; resolve the first with a mispredict while a new predict_valid is asserted the same cycle -> one upd_valid pulse; queue count 0. A further resolve sets err_underflow=1 with no upd_valid.
6. Reset mid-run: with 2 entries pending, assert reset 1 cycle -> no upd_valid for the pending entries; err_underflow=0; init sweep restarts at index 0.
